// File: rtl/eth_pkg.sv
// Shared Ethernet ingress definitions: header layout, CRC-32 constants and
// the parser state encoding used by the switch ingress path.
package eth_pkg;

    localparam int HEADER_DWIDTH  = 128;
    localparam int HDR_FIELD_BITS = 112;
    localparam int HDR_BYTES      = 14;

    localparam int HDR_VALID_BIT = 115;
    localparam int HDR_CTRL_BIT  = 114;
    localparam int HDR_PORT_HI   = 113;
    localparam int HDR_PORT_LO   = 112;
    localparam int HDR_DST_HI    = 111;
    localparam int HDR_DST_LO    = 64;
    localparam int HDR_SRC_HI    = 63;
    localparam int HDR_SRC_LO    = 16;
    localparam int HDR_TYPE_HI   = 15;
    localparam int HDR_TYPE_LO   = 0;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam logic [43:0] CTRL_MAC_PREFIX = 44'h0180C200000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_COMMIT,
        ST_DROP
    } parse_state_t;

    // 01:80:C2:00:00:0X is the IEEE reserved link-local block (BPDU, PAUSE, LACP...).
    function automatic logic is_ctrl_mac(input logic [47:0] dst);
        return dst[47:4] == CTRL_MAC_PREFIX;
    endfunction

    function automatic logic [HEADER_DWIDTH-1:0] make_header(
        input logic                      valid,
        input logic [1:0]                port,
        input logic [HDR_FIELD_BITS-1:0] fields
    );
        logic [HEADER_DWIDTH-1:0] h;
        h = '0;
        h[HDR_VALID_BIT]               = valid;
        h[HDR_CTRL_BIT]                = is_ctrl_mac(fields[HDR_DST_HI:HDR_DST_LO]);
        h[HDR_PORT_HI:HDR_PORT_LO]     = port;
        h[HDR_DST_HI:HDR_DST_LO]       = fields[HDR_DST_HI:HDR_DST_LO];
        h[HDR_SRC_HI:HDR_SRC_LO]       = fields[HDR_SRC_HI:HDR_SRC_LO];
        h[HDR_TYPE_HI:HDR_TYPE_LO]     = fields[HDR_TYPE_HI:HDR_TYPE_LO];
        return h;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected, 0xEDB88320) update for one byte.
// The CRC state register lives in the caller.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        // NOTE: blocking assignments here so each loop step sees the previous one.
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rx_frame_parser.sv
// Per-PHY ingress parser: writes the frame body (FCS included) to the body
// FIFO and one 128-bit header word per frame to the header FIFO.
module rx_frame_parser
    import eth_pkg::*;
#(
    parameter logic [1:0] PORT_ID   = 2'd0,
    parameter int         MIN_FRAME = 64,
    parameter int         MAX_FRAME = 1518
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_dv,
    input  logic                     rx_er,
    output logic [HEADER_DWIDTH-1:0] h_fifo_din,
    output logic                     h_fifo_wren,
    input  logic                     h_fifo_afull,
    output logic [7:0]               b_fifo_din,
    output logic                     b_fifo_del,
    output logic                     b_fifo_wren,
    input  logic                     b_fifo_afull,
    output logic [15:0]              drop_cnt
);

    localparam logic [10:0] CNT_SAT = 11'h7FF;

    parse_state_t              state;
    logic [31:0]               crc;
    logic [10:0]               byte_cnt;
    logic [HDR_FIELD_BITS-1:0] hdr_fields;
    logic [7:0]                hold_byte;
    logic                      err_seen;
    logic                      truncated;
    logic                      hdr_owed;
    logic                      wait_gap;

    logic        sof;
    logic [31:0] crc_seed;
    logic [31:0] crc_next;
    logic [10:0] cnt_next;
    logic [15:0] drop_next;
    logic        frame_ok;

    // A new frame may start right in the COMMIT cycle when the gap is one cycle.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        sof      = 1'b0;
        crc_seed = crc;
        if (rx_dv && ((state == ST_IDLE && !wait_gap) || state == ST_COMMIT)) begin
            sof      = 1'b1;
            crc_seed = CRC32_INIT;
        end
    end

    crc32_d8 u_crc (
        .crc_in  (crc_seed),
        .data    (rx_data),
        .crc_out (crc_next)
    );

    assign cnt_next  = (byte_cnt == CNT_SAT) ? byte_cnt : byte_cnt + 11'd1;
    assign drop_next = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
    assign frame_ok  = (crc == CRC32_RESIDUE) &&
                       (int'(byte_cnt) >= MIN_FRAME) &&
                       (int'(byte_cnt) <= MAX_FRAME) &&
                       !err_seen && !truncated;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            crc         <= CRC32_INIT;
            byte_cnt    <= '0;
            hdr_fields  <= '0;
            hold_byte   <= '0;
            err_seen    <= 1'b0;
            truncated   <= 1'b0;
            hdr_owed    <= 1'b0;
            wait_gap    <= 1'b1;
            h_fifo_din  <= '0;
            h_fifo_wren <= 1'b0;
            b_fifo_din  <= '0;
            b_fifo_del  <= 1'b0;
            b_fifo_wren <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            // NOTE: non-blocking only in sequential logic; later assignments win.
            h_fifo_wren <= 1'b0;
            b_fifo_wren <= 1'b0;
            b_fifo_del  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!rx_dv) wait_gap <= 1'b0;
                end

                ST_HDR: begin
                    if (rx_dv) begin
                        byte_cnt <= cnt_next;
                        crc      <= crc_next;
                        err_seen <= err_seen | rx_er;
                        if (int'(byte_cnt) < HDR_BYTES) begin
                            hdr_fields <= {hdr_fields[HDR_FIELD_BITS-9:0], rx_data};
                        end else begin
                            hold_byte <= rx_data;
                            state     <= ST_BODY;
                        end
                    end else begin
                        drop_cnt <= drop_next;
                        state    <= ST_IDLE;
                    end
                end

                ST_BODY: begin
                    b_fifo_wren <= 1'b1;
                    b_fifo_din  <= hold_byte;
                    if (rx_dv) begin
                        byte_cnt <= cnt_next;
                        crc      <= crc_next;
                        err_seen <= err_seen | rx_er;
                        hold_byte <= rx_data;
                        if (int'(cnt_next) == MAX_FRAME + 1) begin
                            b_fifo_del <= 1'b1;
                            truncated  <= 1'b1;
                            hdr_owed   <= 1'b1;
                            state      <= ST_DROP;
                        end
                    end else begin
                        b_fifo_del <= 1'b1;
                        state      <= ST_COMMIT;
                    end
                end

                ST_COMMIT: begin
                    h_fifo_wren <= 1'b1;
                    h_fifo_din  <= make_header(frame_ok, PORT_ID, hdr_fields);
                    state       <= ST_IDLE;
                end

                ST_DROP: begin
                    if (rx_dv) begin
                        byte_cnt <= cnt_next;
                    end else begin
                        if (hdr_owed) begin
                            h_fifo_wren <= 1'b1;
                            h_fifo_din  <= make_header(1'b0, PORT_ID, hdr_fields);
                        end
                        hdr_owed <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase

            if (sof) begin
                byte_cnt <= 11'd1;
                if (h_fifo_afull || b_fifo_afull) begin
                    drop_cnt <= drop_next;
                    state    <= ST_DROP;
                end else begin
                    hdr_fields <= {hdr_fields[HDR_FIELD_BITS-9:0], rx_data};
                    crc        <= crc_next;
                    err_seen   <= rx_er;
                    truncated  <= 1'b0;
                    state      <= ST_HDR;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: good/bad/control frames, runt, FIFO
// pressure, truncation and mid-frame reset.
module tb_rx_frame_parser;

    logic         clk;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_dv;
    logic         rx_er;
    logic [127:0] h_fifo_din;
    logic         h_fifo_wren;
    logic         h_fifo_afull;
    logic [7:0]   b_fifo_din;
    logic         b_fifo_del;
    logic         b_fifo_wren;
    logic         b_fifo_afull;
    logic [15:0]  drop_cnt;

    rx_frame_parser #(
        .PORT_ID   (2'd2),
        .MIN_FRAME (64),
        .MAX_FRAME (1518)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_dv        (rx_dv),
        .rx_er        (rx_er),
        .h_fifo_din   (h_fifo_din),
        .h_fifo_wren  (h_fifo_wren),
        .h_fifo_afull (h_fifo_afull),
        .b_fifo_din   (b_fifo_din),
        .b_fifo_del   (b_fifo_del),
        .b_fifo_wren  (b_fifo_wren),
        .b_fifo_afull (b_fifo_afull),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [47:0] DST_A  = 48'h001122334455;
    localparam logic [47:0] DST_BP = 48'h0180C2000000;
    localparam logic [47:0] SRC_A  = 48'h66778899AABB;
    localparam logic [127:0] H_GOOD = {12'h0, 1'b1, 1'b0, 2'd2, DST_A, SRC_A, 16'h0800};
    localparam logic [127:0] H_BAD  = {12'h0, 1'b0, 1'b0, 2'd2, DST_A, SRC_A, 16'h0800};
    localparam logic [127:0] H_BPDU = {12'h0, 1'b1, 1'b1, 2'd2, DST_BP, SRC_A, 16'h0026};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Free-running cycle stamp and output monitor (sampled on the falling edge).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           b_pushes = 0;
    int           d_pushes = 0;
    int           h_pushes = 0;
    int           del_cyc  = 0;
    int           hdr_cyc  = 0;
    logic [127:0] hdr_last = '0;
    logic [7:0]   last_din = '0;
    logic         last_del = 1'b0;

    always @(negedge clk) begin
        if (b_fifo_wren) begin
            b_pushes++;
            last_din = b_fifo_din;
            last_del = b_fifo_del;
            if (b_fifo_del) begin
                d_pushes++;
                del_cyc = cyc;
            end
        end
        if (h_fifo_wren) begin
            h_pushes++;
            hdr_last = h_fifo_din;
            hdr_cyc  = cyc;
        end
    end

    logic [7:0] frm [0:1599];
    int         fall_cyc;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] typ, input int len);
        logic [31:0] c;
        for (int i = 0; i < 6; i++) begin
            frm[i]     = dst[47-8*i -: 8];
            frm[6 + i] = src[47-8*i -: 8];
        end
        frm[12] = typ[15:8];
        frm[13] = typ[7:0];
        for (int i = 14; i < len; i++) frm[i] = 8'(i * 7 + 3);
        if (len >= 18) begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < len - 4; i++) c = crc_upd(c, frm[i]);
            c = ~c;
            frm[len-4] = c[7:0];
            frm[len-3] = c[15:8];
            frm[len-2] = c[23:16];
            frm[len-1] = c[31:24];
        end
    endtask

    task automatic send_frame(input int len, input bit afull_mid);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            rx_dv   = 1'b1;
            rx_data = frm[i];
            if (afull_mid) b_fifo_afull = (i >= 10 && i < 60);
        end
        @(negedge clk);
        rx_dv    = 1'b0;
        rx_data  = 8'h00;
        fall_cyc = cyc;
        if (afull_mid) b_fifo_afull = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // del_lat/hdr_lat of 0 skip that latency check.
    task automatic expect_frame(input string nm, input int len, input bit afull_mid,
                                input int exp_body, input int exp_hdr,
                                input logic [127:0] exp_word, input logic [7:0] exp_last,
                                input int del_lat, input int hdr_lat);
        int b0, d0, h0;
        b0 = b_pushes;
        d0 = d_pushes;
        h0 = h_pushes;
        send_frame(len, afull_mid);
        check({nm, ".body_pushes"}, 128'(b_pushes - b0), 128'(exp_body));
        check({nm, ".hdr_pushes"},  128'(h_pushes - h0), 128'(exp_hdr));
        check({nm, ".delims"},      128'(d_pushes - d0), 128'(exp_body > 0 ? 1 : 0));
        if (exp_body > 0) begin
            check({nm, ".del_on_last"}, 128'(last_del), 128'(1));
            check({nm, ".last_byte"},   128'(last_din), 128'(exp_last));
            if (del_lat > 0) check({nm, ".del_latency"}, 128'(del_cyc - fall_cyc), 128'(del_lat));
        end
        if (exp_hdr > 0) begin
            check({nm, ".hdr_word"}, hdr_last, exp_word);
            if (hdr_lat > 0) check({nm, ".hdr_latency"}, 128'(hdr_cyc - fall_cyc), 128'(hdr_lat));
        end
    endtask

    initial begin
        int b0, h0;
        rst          = 1'b1;
        rx_data      = 8'h00;
        rx_dv        = 1'b0;
        rx_er        = 1'b0;
        h_fifo_afull = 1'b0;
        b_fifo_afull = 1'b0;
        repeat (3) @(negedge clk);

        check("reset.h_fifo_din",  h_fifo_din,           128'h0);
        check("reset.h_fifo_wren", 128'(h_fifo_wren),    128'h0);
        check("reset.b_fifo_din",  128'(b_fifo_din),     128'h0);
        check("reset.b_fifo_del",  128'(b_fifo_del),     128'h0);
        check("reset.b_fifo_wren", 128'(b_fifo_wren),    128'h0);
        check("reset.drop_cnt",    128'(drop_cnt),       128'h0);

        rst = 1'b0;
        repeat (2) @(negedge clk);

        build_frame(DST_A, SRC_A, 16'h0800, 64);
        expect_frame("good64", 64, 1'b0, 50, 1, H_GOOD, frm[63], 1, 2);

        build_frame(DST_A, SRC_A, 16'h0800, 64);
        frm[20] = frm[20] ^ 8'h01;
        expect_frame("badfcs", 64, 1'b0, 50, 1, H_BAD, frm[63], 1, 2);

        build_frame(DST_BP, SRC_A, 16'h0026, 64);
        expect_frame("bpdu", 64, 1'b0, 50, 1, H_BPDU, frm[63], 1, 2);

        build_frame(DST_A, SRC_A, 16'h0800, 10);
        expect_frame("runt", 10, 1'b0, 0, 0, '0, 8'h00, 0, 0);
        check("runt.drop_cnt", 128'(drop_cnt), 128'(1));

        build_frame(DST_A, SRC_A, 16'h0800, 64);
        expect_frame("after_runt", 64, 1'b0, 50, 1, H_GOOD, frm[63], 1, 2);

        @(negedge clk);
        b_fifo_afull = 1'b1;
        build_frame(DST_A, SRC_A, 16'h0800, 100);
        expect_frame("afull_sof", 100, 1'b0, 0, 0, '0, 8'h00, 0, 0);
        b_fifo_afull = 1'b0;
        check("afull_sof.drop_cnt", 128'(drop_cnt), 128'(2));

        build_frame(DST_A, SRC_A, 16'h0800, 100);
        expect_frame("afull_mid", 100, 1'b1, 86, 1, H_GOOD, frm[99], 1, 2);
        check("afull_mid.drop_cnt", 128'(drop_cnt), 128'(2));

        build_frame(DST_A, SRC_A, 16'h0800, 1600);
        expect_frame("trunc1600", 1600, 1'b0, 1504, 1, H_BAD, frm[1517], 0, 1);
        check("trunc1600.drop_cnt", 128'(drop_cnt), 128'(2));

        // Reset in the middle of a body, released while the frame is still arriving.
        build_frame(DST_A, SRC_A, 16'h0800, 100);
        b0 = 0;
        h0 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 42) begin
                check("midrst.b_fifo_wren", 128'(b_fifo_wren), 128'h0);
                check("midrst.b_fifo_din",  128'(b_fifo_din),  128'h0);
                check("midrst.h_fifo_wren", 128'(h_fifo_wren), 128'h0);
                check("midrst.h_fifo_din",  h_fifo_din,        128'h0);
                check("midrst.drop_cnt",    128'(drop_cnt),    128'h0);
            end
            if (i == 40) rst = 1'b1;
            if (i == 43) begin
                rst = 1'b0;
                b0  = b_pushes;
                h0  = h_pushes;
            end
            rx_dv   = 1'b1;
            rx_data = frm[i];
        end
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        repeat (6) @(negedge clk);
        check("midrst.tail_body", 128'(b_pushes - b0), 128'h0);
        check("midrst.tail_hdr",  128'(h_pushes - h0), 128'h0);

        build_frame(DST_A, SRC_A, 16'h0800, 64);
        expect_frame("after_rst", 64, 1'b0, 50, 1, H_GOOD, frm[63], 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
